frame_packager_n: RTL

Parametrised successor to the fixed 6-channel packager. On each word_clk-style strobe it snapshots NUM_CH filtered ADC words and emits a byte frame over a valid/ready byte stream toward uart_tx or manch_encoding. The frame is SYNC, SEQ, channel data MSB-first, then an optional CRC-8. Adds variable width and channel count, a frame sequence counter, CRC, and sticky overrun detection.

---
 rtl/frame_pkg.sv | 28 ++
 rtl/crc8_byte.sv | 12 +
 rtl/frame_packager_n.sv | 129 ++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types, constants and helpers for the frame packager
package frame_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SYNC = 3'd1;
  localparam state_t ST_SEQ  = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_CRC  = 3'd4;

  localparam logic [7:0] CRC_POLY = 8'h07;

  // CRC-8, MSB-first, no reflection, no final XOR
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic int bytes_per_ch(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/crc8_byte.sv
// rtl/crc8_byte.sv - combinational one-byte CRC-8 update
module crc8_byte
  import frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_next(crc_in, data_in);

endmodule

// File: rtl/frame_packager_n.sv
// rtl/frame_packager_n.sv - snapshots NUM_CH samples per strobe and streams SYNC, SEQ, data, CRC bytes
module frame_packager_n
  import frame_pkg::*;
#(
  parameter int         NUM_CH    = 6,
  parameter int         WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CRC_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [NUM_CH*WIDTH-1:0] sample_data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic [7:0]              seq_num
);

  localparam int         BPC      = bytes_per_ch(WIDTH);
  localparam logic [4:0] LAST_CH  = 5'(NUM_CH - 1);
  localparam logic [2:0] LAST_IDX = 3'(BPC - 1);

  state_t                    state;
  logic [NUM_CH*WIDTH-1:0]   snap;
  logic [4:0]                ch;
  logic [2:0]                byte_idx;
  logic [7:0]                crc;
  logic [7:0]                crc_nxt;
  logic [WIDTH-1:0]          cur_sample;
  logic [BPC*8-1:0]          cur_ext;
  logic [7:0]                data_byte;
  logic                      xfer;
  logic                      final_xfer;

  assign busy     = (state != ST_IDLE);
  assign tx_valid = busy;
  assign xfer     = tx_valid && tx_ready;

  // Sample is zero-extended to whole bytes and sent MSB byte first
  always_comb begin
    cur_sample = WIDTH'(snap >> (ch * WIDTH));
    cur_ext    = '0;
    cur_ext[WIDTH-1:0] = cur_sample;
    data_byte  = 8'(cur_ext >> {byte_idx, 3'b000});
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_SYNC: tx_data = SYNC_BYTE;
      ST_SEQ:  tx_data = seq_num;
      ST_DATA: tx_data = data_byte;
      ST_CRC:  tx_data = crc;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    if (CRC_EN != 0) final_xfer = xfer && (state == ST_CRC);
    else             final_xfer = xfer && (state == ST_DATA) && (ch == LAST_CH) && (byte_idx == 3'd0);
  end

  crc8_byte u_crc (
    .crc_in  (crc),
    .data_in (tx_data),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      snap     <= '0;
      ch       <= '0;
      byte_idx <= '0;
      crc      <= '0;
      seq_num  <= '0;
      overrun  <= 1'b0;
    end else begin
      // A strobe landing on the final-byte transfer starts the next frame instead
      if (sample_valid && busy && !final_xfer) overrun <= 1'b1;
      else if (overrun_clr)                    overrun <= 1'b0;

      case (state)
        ST_IDLE: if (sample_valid) begin
          snap  <= sample_data;
          crc   <= '0;
          state <= ST_SYNC;
        end
        ST_SYNC: if (xfer) state <= ST_SEQ;
        ST_SEQ: if (xfer) begin
          crc      <= crc_nxt;
          ch       <= '0;
          byte_idx <= LAST_IDX;
          state    <= ST_DATA;
        end
        ST_DATA: if (xfer) begin
          crc <= crc_nxt;
          if (byte_idx != 3'd0) begin
            byte_idx <= byte_idx - 3'd1;
          end else if (ch != LAST_CH) begin
            ch       <= ch + 5'd1;
            byte_idx <= LAST_IDX;
          end else if (CRC_EN != 0) begin
            state <= ST_CRC;
          end
        end
        ST_CRC: begin
        end
        default: state <= ST_IDLE;
      endcase

      if (final_xfer) begin
        seq_num <= seq_num + 8'd1;
        if (sample_valid) begin
          snap  <= sample_data;
          crc   <= '0;
          state <= ST_SYNC;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule
